// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch stage.
package fetch_pkg;

    localparam int XLEN        = 32;
    localparam int INSTR_BYTES = 4;

    // One fetched instruction together with the address it was read from.
    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] instr;
    } fetch_entry_t;

endpackage

// File: rtl/fetch_skid_buf.sv
// Two-entry FIFO that holds fetched instructions between memory and decode.
// slot0 is always the head; slot1 is only meaningful when count == 2.
module fetch_skid_buf
    import fetch_pkg::*;
(
    input  logic         clk,
    input  logic         rst_n,
    input  logic         enq,
    input  fetch_entry_t enq_data,
    input  logic         deq,
    input  logic         flush,
    output logic [1:0]   count,
    output fetch_entry_t head
);

    fetch_entry_t slot0;
    fetch_entry_t slot1;
    logic         deq_ok;
    logic         enq_ok;

    assign head = slot0;

    // Qualify requests so the FIFO can never underflow or overflow.
    always_comb begin
        deq_ok = deq && (count != 2'd0);
        enq_ok = enq && ((count != 2'd2) || deq_ok);
    end

    // Occupancy: reset and flush empty the FIFO; data slots need no clearing.
    always_ff @(posedge clk) begin
        if (!rst_n || flush) begin
            count <= 2'd0;
        end else if (enq_ok && !deq_ok) begin
            count <= count + 2'd1;
        end else if (deq_ok && !enq_ok) begin
            count <= count - 2'd1;
        end
    end

    // Entry storage: dequeue shifts slot1 forward, enqueue fills the first free slot.
    always_ff @(posedge clk) begin
        if (deq_ok) begin
            if (enq_ok && count == 2'd1) begin
                slot0 <= enq_data;
            end else begin
                slot0 <= slot1;
            end
            if (enq_ok && count == 2'd2) begin
                slot1 <= enq_data;
            end
        end else if (enq_ok) begin
            if (count == 2'd0) begin
                slot0 <= enq_data;
            end else begin
                slot1 <= enq_data;
            end
        end
    end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage: PC generation, one-cycle-latency memory requests,
// a two-entry skid buffer towards decode, and branch redirect handling.
// Buffer entries are sized by fetch_pkg::XLEN; keep that equal to XLEN here.
module fetch_unit #(
    parameter int              XLEN     = 32,
    parameter logic [XLEN-1:0] RESET_PC = 32'h0000_0000
) (
    input  logic            clk,
    input  logic            rst_n,
    output logic            imem_req,
    output logic [XLEN-1:0] imem_addr,
    input  logic [XLEN-1:0] imem_rdata,
    input  logic            br_taken,
    input  logic [XLEN-1:0] br_target,
    output logic            if_valid,
    output logic [XLEN-1:0] if_instr,
    output logic [XLEN-1:0] if_pc,
    input  logic            id_ready
);

    import fetch_pkg::*;

    logic [XLEN-1:0] pc;
    logic            inflight;
    logic [XLEN-1:0] inflight_pc;
    logic [1:0]      buf_count;
    fetch_entry_t    buf_head;
    fetch_entry_t    enq_entry;
    logic            enq;
    logic            deq;
    logic [1:0]      occ_after;
    logic [1:0]      occ_total;
    logic            issue;

    assign imem_addr = pc;
    assign imem_req  = issue;
    assign if_valid  = rst_n && (buf_count != 2'd0) && !br_taken;
    assign if_instr  = buf_head.instr;
    assign if_pc     = buf_head.pc;

    // Issue only when the returning word is guaranteed a free buffer slot;
    // a redirect suppresses both issue and capture of the arriving word.
    always_comb begin
        deq             = if_valid && id_ready;
        enq             = inflight && !br_taken;
        occ_after       = buf_count - {1'b0, deq};
        occ_total       = occ_after + {1'b0, inflight};
        issue           = rst_n && !br_taken && (occ_total < 2'd2);
        enq_entry.pc    = inflight_pc;
        enq_entry.instr = imem_rdata;
    end

    // PC and in-flight flag: redirect overrides sequential advance.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pc       <= RESET_PC;
            inflight <= 1'b0;
        end else begin
            inflight <= issue;
            if (br_taken) begin
                pc <= {br_target[XLEN-1:2], 2'b00};
            end else if (issue) begin
                pc <= pc + XLEN'(INSTR_BYTES);
            end
        end
    end

    // Remember the address of the outstanding request to tag its response.
    always_ff @(posedge clk) begin
        if (issue) begin
            inflight_pc <= pc;
        end
    end

    fetch_skid_buf u_skid_buf (
        .clk      (clk),
        .rst_n    (rst_n),
        .enq      (enq),
        .enq_data (enq_entry),
        .deq      (deq),
        .flush    (br_taken),
        .count    (buf_count),
        .head     (buf_head)
    );

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: directed timing scenarios plus a
// randomized run scored against an instruction-stream reference model.
module tb_fetch_unit;

    localparam int          XLEN   = 32;
    localparam logic [31:0] RST_PC = 32'h0000_0000;

    logic        clk        = 1'b0;
    logic        rst_n      = 1'b0;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic [31:0] imem_rdata;
    logic        br_taken   = 1'b0;
    logic [31:0] br_target  = 32'h0;
    logic        if_valid;
    logic [31:0] if_instr;
    logic [31:0] if_pc;
    logic        id_ready   = 1'b0;

    int n_checks = 0;
    int n_errors = 0;
    int xfers    = 0;

    fetch_unit #(.XLEN(XLEN), .RESET_PC(RST_PC)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .imem_req   (imem_req),
        .imem_addr  (imem_addr),
        .imem_rdata (imem_rdata),
        .br_taken   (br_taken),
        .br_target  (br_target),
        .if_valid   (if_valid),
        .if_instr   (if_instr),
        .if_pc      (if_pc),
        .id_ready   (id_ready)
    );

    always #5 clk = ~clk;

    // Memory: word at addr is addr>>2, returned one cycle after the request;
    // garbage otherwise so that any unrequested capture is visible.
    always @(posedge clk) begin
        if (imem_req) imem_rdata <= imem_addr >> 2;
        else          imem_rdata <= $urandom;
    end

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h at %0t", tag, act, exp, $time);
        end
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset();
        rst_n    = 1'b0;
        br_taken = 1'b0;
        next_cycle();
        @(negedge clk);
        check_eq("rst_if_valid", 32'(if_valid), 32'd0);
        check_eq("rst_imem_req", 32'(imem_req), 32'd0);
        next_cycle();
        rst_n = 1'b1;
    endtask

    // Reference model: the decode side must see one unbroken sequential
    // instruction stream starting at RESET_PC after reset or at the aligned
    // target after a redirect, with word = address/4, and a stalled offer
    // must stay put.
    initial begin
        logic [31:0] exp_pc;
        logic [31:0] ppc;
        logic [31:0] pinstr;
        bit          pv;
        bit          pr;
        bit          prst;
        exp_pc = RST_PC;
        pv = 0; pr = 0; prst = 0; ppc = '0; pinstr = '0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                exp_pc = RST_PC;
            end else begin
                if (prst && pv && !pr && !br_taken) begin
                    check_eq("m_stall_valid", 32'(if_valid), 32'd1);
                    check_eq("m_stall_pc", if_pc, ppc);
                    check_eq("m_stall_instr", if_instr, pinstr);
                end
                if (br_taken) begin
                    check_eq("m_req_on_br", 32'(imem_req), 32'd0);
                    check_eq("m_valid_on_br", 32'(if_valid), 32'd0);
                end
                if (if_valid && id_ready) begin
                    check_eq("m_xfer_pc", if_pc, exp_pc);
                    check_eq("m_xfer_instr", if_instr, exp_pc >> 2);
                    exp_pc = exp_pc + 32'd4;
                    xfers++;
                end
                if (br_taken) exp_pc = {br_target[31:2], 2'b00};
            end
            pv     = (if_valid === 1'b1);
            pr     = (id_ready === 1'b1);
            prst   = (rst_n === 1'b1);
            ppc    = if_pc;
            pinstr = if_instr;
        end
    end

    initial begin
        int base_xfers;

        // Free-running fetch from reset.
        apply_reset();
        id_ready = 1'b1;
        for (int c = 0; c < 12; c++) begin
            @(negedge clk);
            if (c == 0) begin
                check_eq("t1_req_c0", 32'(imem_req), 32'd1);
                check_eq("t1_addr_c0", imem_addr, RST_PC);
            end
            if (c < 2) begin
                check_eq("t1_novalid", 32'(if_valid), 32'd0);
            end else begin
                check_eq("t1_valid", 32'(if_valid), 32'd1);
                check_eq("t1_pc", if_pc, RST_PC + 32'((c - 2) * 4));
                check_eq("t1_instr", if_instr, 32'(c - 2));
            end
            next_cycle();
        end

        // Decode stall for 10 cycles after the first offer.
        apply_reset();
        for (int c = 0; c < 16; c++) begin
            id_ready = (c < 2) || (c >= 12);
            @(negedge clk);
            if (c >= 3 && c <= 11) begin
                check_eq("t2_full_req", 32'(imem_req), 32'd0);
                check_eq("t2_hold_valid", 32'(if_valid), 32'd1);
                check_eq("t2_hold_pc", if_pc, 32'h0);
            end
            if (c >= 12) begin
                check_eq("t2_rel_valid", 32'(if_valid), 32'd1);
                check_eq("t2_rel_pc", if_pc, 32'((c - 12) * 4));
            end
            next_cycle();
        end

        // Redirect latency.
        apply_reset();
        id_ready  = 1'b1;
        br_target = 32'h0000_0103;
        for (int c = 0; c < 12; c++) begin
            br_taken = (c == 6);
            @(negedge clk);
            if (c == 6) check_eq("t3_req_br", 32'(imem_req), 32'd0);
            if (c == 7) begin
                check_eq("t3_req_tgt", 32'(imem_req), 32'd1);
                check_eq("t3_addr_tgt", imem_addr, 32'h100);
            end
            if (c == 7 || c == 8) check_eq("t3_gap", 32'(if_valid), 32'd0);
            if (c == 9) begin
                check_eq("t3_valid", 32'(if_valid), 32'd1);
                check_eq("t3_pc", if_pc, 32'h100);
                check_eq("t3_instr", if_instr, 32'h40);
            end
            if (c == 10) check_eq("t3_pc_next", if_pc, 32'h104);
            next_cycle();
        end
        br_taken = 1'b0;

        // Redirect with a full buffer and decode stalled.
        apply_reset();
        br_target = 32'h0000_0080;
        for (int c = 0; c < 10; c++) begin
            id_ready = (c >= 6);
            br_taken = (c == 5);
            @(negedge clk);
            if (c == 4) begin
                check_eq("t4_full_req", 32'(imem_req), 32'd0);
                check_eq("t4_full_pc", if_pc, 32'h0);
            end
            if (c == 6 || c == 7) check_eq("t4_flushed", 32'(if_valid), 32'd0);
            if (c == 8) begin
                check_eq("t4_valid", 32'(if_valid), 32'd1);
                check_eq("t4_pc", if_pc, 32'h80);
            end
            next_cycle();
        end
        br_taken = 1'b0;

        // Back-to-back redirects: the later one wins.
        apply_reset();
        id_ready = 1'b1;
        for (int c = 0; c < 10; c++) begin
            br_taken  = (c == 4) || (c == 5);
            br_target = (c == 4) ? 32'h200 : 32'h300;
            @(negedge clk);
            if (c == 6) check_eq("t5_addr", imem_addr, 32'h300);
            if (c == 7) check_eq("t5_gap", 32'(if_valid), 32'd0);
            if (c == 8) begin
                check_eq("t5_valid", 32'(if_valid), 32'd1);
                check_eq("t5_pc", if_pc, 32'h300);
            end
            next_cycle();
        end
        br_taken = 1'b0;

        // Address wrap-around, then a reset pulse mid-stream.
        apply_reset();
        id_ready  = 1'b1;
        br_target = 32'hFFFF_FFF8;
        for (int c = 0; c < 16; c++) begin
            br_taken = (c == 3);
            rst_n    = (c != 10);
            @(negedge clk);
            if (c == 7) check_eq("t6_pc_top", if_pc, 32'hFFFF_FFFC);
            if (c == 8) begin
                check_eq("t6_wrap_valid", 32'(if_valid), 32'd1);
                check_eq("t6_wrap_pc", if_pc, 32'h0);
            end
            if (c == 10) begin
                check_eq("t6_rst_valid", 32'(if_valid), 32'd0);
                check_eq("t6_rst_req", 32'(imem_req), 32'd0);
            end
            if (c == 11) check_eq("t6_restart_addr", imem_addr, RST_PC);
            if (c == 11 || c == 12) check_eq("t6_no_stale", 32'(if_valid), 32'd0);
            if (c == 13) begin
                check_eq("t6_restart_valid", 32'(if_valid), 32'd1);
                check_eq("t6_restart_pc", if_pc, RST_PC);
            end
            next_cycle();
        end
        br_taken = 1'b0;
        rst_n    = 1'b1;

        // Randomized traffic scored by the stream model.
        base_xfers = xfers;
        for (int c = 0; c < 3000; c++) begin
            id_ready  = ($urandom_range(0, 9) < 7);
            br_taken  = ($urandom_range(0, 19) == 0);
            br_target = $urandom;
            rst_n     = ($urandom_range(0, 199) != 0);
            next_cycle();
        end
        br_taken = 1'b0;
        rst_n    = 1'b1;
        @(negedge clk);
        check_eq("rand_progress", 32'((xfers - base_xfers) > 300), 32'd1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
